// File: rtl/pes_mul_result_buffer.sv
// pes_mul_result_buffer
//
// Latency-tracking result buffer wrapped around a pipelined multiplier
// (pes_pipeline_mul). Operand pairs accepted on the s_* handshake go straight
// to the multiplier inputs. A one-bit tag per accepted pair rides a MUL_LAT-deep
// shift register alongside the multiplier pipeline. When a tag reaches the end
// of that register, mul_f is captured into a first-word-fall-through FIFO that
// feeds the m_* handshake.
//
// Admission is credit based. occupancy counts queued results plus products
// still inside the multiplier. A pair is accepted only while occupancy < DEPTH,
// so the FIFO cannot overflow even when the downstream stalls indefinitely.
//
// Parameters
//   WIDTH    operand / product width
//   MUL_LAT  cycles from operand-sampling edge to product valid on mul_f (>=1)
//   DEPTH    FIFO entries (power of 2, >=2)
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   s_valid/s_ready   operand handshake; s_a, s_b operands
//   mul_a, mul_b      combinational copies of s_a, s_b to the multiplier
//   mul_f             multiplier product
//   m_valid/m_ready   result handshake; m_data is the FIFO head (0 when empty)
//   occupancy         queued results plus in-flight products
//   issue_cnt         accepted pairs (16-bit, wraps)
//   done_cnt          popped results (16-bit, wraps)
//
// Optional feature: define PES_MULBUF_STATS_EN to build the issue/done
// counters. Without it both ports read 0 and no counter flops exist.

module pes_mul_result_buffer #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 3,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_a,
    input  logic [WIDTH-1:0]           s_b,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [WIDTH-1:0]           mul_f,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [15:0]                issue_cnt,
    output logic [15:0]                done_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int OW = AW + 1;

    // Number of products currently inside the multiplier. The true total
    // (count + in-flight) never exceeds DEPTH, so OW bits are enough.
    function automatic logic [OW-1:0] tag_count(input logic [MUL_LAT-1:0] t);
        logic [OW-1:0] n;
        n = '0;
        for (int i = 0; i < MUL_LAT; i++) begin
            n = n + OW'(t[i]);
        end
        return n;
    endfunction

    logic [MUL_LAT-1:0] tag;
    logic [WIDTH-1:0]   mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [OW-1:0]      count;
    logic               fire_in;
    logic               push;
    logic               pop;

    assign mul_a = s_a;
    assign mul_b = s_b;

    assign occupancy = count + tag_count(tag);

    // Credit check uses registered state only; a pop in this same cycle is
    // deliberately not credited, which keeps s_ready off the m_ready path.
    assign s_ready = !rst && (occupancy < OW'(DEPTH));
    assign fire_in = s_valid && s_ready;

    assign m_valid = (count != '0);
    assign m_data  = m_valid ? mem[rd_ptr] : '0;
    assign pop     = m_valid && m_ready;

    // The product for a tag leaving the last stage is on mul_f right now.
    assign push = tag[MUL_LAT-1];

    // Tag pipe and FIFO control
    always_ff @(posedge clk) begin
        if (rst) begin
            tag    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            tag[0] <= fire_in;
            for (int i = 1; i < MUL_LAT; i++) begin
                tag[i] <= tag[i-1];
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + OW'(push) - OW'(pop);
        end
    end

    // FIFO storage (data only, no reset)
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= mul_f;
        end
    end

`ifdef PES_MULBUF_STATS_EN
    logic [15:0] issue_q;
    logic [15:0] done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issue_q <= '0;
            done_q  <= '0;
        end else begin
            if (fire_in) begin
                issue_q <= issue_q + 16'd1;
            end
            if (pop) begin
                done_q <= done_q + 16'd1;
            end
        end
    end

    assign issue_cnt = issue_q;
    assign done_cnt  = done_q;
`else
    assign issue_cnt = '0;
    assign done_cnt  = '0;
`endif

endmodule

// File: doc/pes_mul_result_buffer.md
Name: pes_mul_result_buffer

Overview:
Latency-tracking result buffer placed directly downstream of (and wrapped around) the pes_pipeline_mul datapath.
- Accepts operand pairs on a valid/ready interface and drives them straight onto the multiplier inputs.
- Tags each accepted pair with a valid bit that travels through a MUL_LAT-deep shift register, so the multiplier's F output is captured exactly when the matching product emerges.
- Captured products are queued in a first-word-fall-through FIFO and offered downstream on a valid/ready interface.
- Credit-based admission: the FIFO can never overflow, even with downstream fully stalled.

Parameters:
WIDTH, 32, operand/product width (matches multiplier A/B/F)
MUL_LAT, 3, cycles from operand-sampling edge to product valid on mul_f (≥1)
DEPTH, 8, FIFO entries (power of 2, ≥2)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
s_valid  input  1  operand pair available
s_ready  output  1  buffer can accept a pair this cycle
s_a  input  WIDTH  operand A
s_b  input  WIDTH  operand B
mul_a  output  WIDTH  to multiplier A
mul_b  output  WIDTH  to multiplier B
mul_f  input  WIDTH  from multiplier F
m_valid  output  1  result available
m_ready  input  1  downstream accepts result
m_data  output  WIDTH  result at FIFO head
occupancy  output  $clog2(DEPTH)+1  FIFO entries plus in-flight products
issue_cnt  output  16  accepted pairs (optional feature)
done_cnt  output  16  results popped (optional feature)

Behaviour:
- Reset, sampled at a rising clk edge:
  - Clears the valid shift register, FIFO pointers and count, and the stats counters.
  - Outputs after the reset edge: s_ready=0 while rst=1; m_valid=0, m_data=0, occupancy=0, issue_cnt=0, done_cnt=0.
  - Mid-operation reset discards all in-flight and queued products. Products emerging after reset are ignored because their tags were cleared.
- Operand path:
  - mul_a=s_a and mul_b=s_b always; the path is combinational, with no gating.
  - fire_in = s_valid & s_ready.
- s_ready = !rst & (occupancy < DEPTH), computed combinationally from registered state only; it is independent of m_ready, and a same-cycle pop is not credited.
- Tag pipe:
  - tag[0] <= fire_in; tag[i] <= tag[i-1].
  - The product for a pair accepted at edge k is present on mul_f in the cycle after edge k+MUL_LAT-1, and is written at edge k+MUL_LAT when tag[MUL_LAT-1]=1.
- FIFO:
  - First-word-fall-through: m_valid = count!=0; m_data = mem[rd_ptr], or 0 when empty.
  - Pop on m_valid & m_ready.
  - Simultaneous push and pop leaves count unchanged. A push into an empty FIFO appears on m_data in the cycle after the write edge.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- occupancy = count + popcount(tag).
  - Next value = occupancy + fire_in - pop.
  - Never exceeds DEPTH; this is guaranteed by the s_ready rule.
- Ordering: results leave in acceptance order. The buffer does not modify data.
- m_ready held low: accepted pairs stop once occupancy reaches DEPTH, and none are lost.
- s_valid with s_ready=0: no tag is inserted; the upstream holds its data.

Optional Feature:
Macro PES_MULBUF_STATS_EN.
- Defined:
  - issue_cnt increments on each fire_in.
  - done_cnt increments on each pop.
  - Both are 16-bit, wrap 0xFFFF→0, and are cleared by rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
- Bench model of the multiplier: low WIDTH bits of A*B, delayed MUL_LAT cycles. Defaults throughout unless stated.
- Single op: rst 2 cycles, then s_a=0x10, s_b=0x1 for one cycle with m_ready=1 → m_valid rises in the cycle after edge k+3, m_data=0x10; occupancy goes 1,1,1,1,0.
- Back-to-back stream: pairs (0xF0,0x40), (0xC000,0x1000), (0x0A01,0x20), one per cycle → outputs in order 0x3C00, 0x0C000000, 0x00014020; no bubbles between m_valid beats.
- Backpressure: m_ready=0, s_valid=1 continuously → exactly 8 accepted; s_ready=0 with occupancy=8; raising m_ready drains all 8 in order, then s_ready returns to 1.
- Simultaneous push and pop at count=4 → count stays 4; pointer wrap verified over 20 items with no duplicates or losses.
- Reset mid-flight: 3 in flight plus 2 queued, assert rst one cycle → m_valid=0 and occupancy=0 next cycle; no stale product appears in the following 5 cycles.
- With PES_MULBUF_STATS_EN: 70000 issued and popped ops → issue_cnt=done_cnt=70000 mod 65536=4464; without the macro both read 0.
